hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline stall controller for the 5-stage MIPS core.
- Decides each cycle whether the fetch PC register and the F/D pipeline register hold, and whether the D/E register is flushed into a bubble.
- Combines Tuse/Tnew data-hazard detection with an internal mult/div busy sequencer.
- Drives the PC register's enable, so it also guarantees that a reset actually reaches the PC.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.
- CNT_W, 4, md counter width; must satisfy max(MULT_CYCLES, DIV_CYCLES) < 2**CNT_W.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- d_rs_addr  in  5  rs index of the D-stage instruction.
- d_rt_addr  in  5  rt index of the D-stage instruction.
- d_rs_tuse  in  2  cycles until rs is needed; 3 = rs unused.
- d_rt_tuse  in  2  cycles until rt is needed; 3 = rt unused.
- d_is_md  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
- e_wa  in  5  E-stage destination register; 0 = none.
- e_tnew  in  2  cycles until the E-stage result is available.
- m_wa  in  5  M-stage destination register; 0 = none.
- m_tnew  in  2  cycles until the M-stage result is available.
- e_md_start  in  1  E-stage holds a mult/div this cycle.
- e_md_is_div  in  1  qualifies e_md_start: 1 = div/divu.
- pc_en  out  1  enable for the PC register.
- fd_en  out  1  enable for the F/D register.
- de_clr  out  1  synchronous clear for the D/E register.
- md_busy  out  1  mult/div unit busy.
- md_count  out  CNT_W  remaining busy cycles.
- stall_cnt  out  32  total stalled cycles since reset.

Behaviour:
- Data hazard on rs (combinational), true when:
  - d_rs_addr != 0, and
  - either (d_rs_addr == e_wa and d_rs_tuse < e_tnew) or (d_rs_addr == m_wa and d_rs_tuse < m_tnew).
- Data hazard on rt: same rule using the rt signals.
- Tuse = 3 never stalls, since tnew is at most 3.
- md hazard = d_is_md & (e_md_start | md_busy).
- stall = rs hazard | rt hazard | md hazard.
- Outside reset: pc_en = ~stall, fd_en = ~stall, de_clr = stall. Same-cycle, zero latency.
- During reset: pc_en = 1, fd_en = 1, de_clr = 1, regardless of other inputs. The PC register gives its enable priority over reset, so reset can only take effect when pc_en is 1.
- md sequencer (registered):
  - reset -> md_count = 0.
  - e_md_start & md_count == 0 -> load DIV_CYCLES if e_md_is_div, else MULT_CYCLES.
  - otherwise, md_count != 0 -> decrement by 1.
  - md_busy = (md_count != 0).
- md timing: a start in cycle t gives md_busy high in cycles t+1 .. t+N (N = loaded value) and low in t+N+1.
- e_md_start while md_count != 0 cannot occur (the D-stage stall prevents it). If it does, it is ignored: no reload, and the decrement continues.
- stall_cnt:
  - reset -> 0.
  - +1 on each clock edge where stall = 1 and reset = 0.
  - Wraps modulo 2^32.
- Reset asserted mid-busy: md_count cleared on that edge; md_busy low the next cycle.
- Reset values: md_count 0, md_busy 0, stall_cnt 0; pc_en/fd_en/de_clr 1/1/1 while reset is held.

Decomposition:
- Shared package holds:
  - TUSE_UNUSED = 2'd3.
  - Default values for MULT_CYCLES and DIV_CYCLES.
  - REG_ZERO = 5'd0.
- One natural sub-module: md_busy_seq, containing the counter, md_busy and md_count.
- Hazard comparison logic and stall_cnt stay in the top module.

Test Plan:
- Load-use: e_wa=8, e_tnew=2, d_rs_addr=8, d_rs_tuse=1 -> stall=1 (pc_en=0, fd_en=0, de_clr=1), stall_cnt +1. Then e_wa=0, m_wa=8, m_tnew=1 -> stall=0.
- $0 exemption: d_rs_addr=0, e_wa=0, e_tnew=2, d_rs_tuse=0 -> no stall. Unused operand: d_rt_tuse=3, rt matches e_wa, e_tnew=2 -> no stall.
- Div: e_md_start=1, e_md_is_div=1 at cycle t, then d_is_md=1 held -> md_count reads 10 at t+1 and counts down to 0 at t+11. stall=1 during t..t+10 and 0 at t+11. stall_cnt increases by exactly 11.
- Mult with unrelated instruction: mult start, d_is_md=0 -> md_busy high for 5 cycles, no stall at any point.
- Reset mid-div with d_is_md=1 (normally a stall): with md_count=6, assert reset for 1 cycle -> during reset pc_en=1 and de_clr=1. After the edge: md_count=0, stall_cnt=0, md_busy=0, stall=0.
- Wrap: force stall_cnt to 0xFFFFFFFF, one stall cycle -> stall_cnt=0.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl_pkg
// Shared constants, types and helpers for the MIPS pipeline stall controller.
//   TUSE_UNUSED      : Tuse encoding meaning "operand not read"
//   REG_ZERO         : architectural $0, never a real dependency
//   MULT/DIV_CYCLES  : default busy lengths of the mult/div unit
//   hazard_hit()     : one producer-vs-consumer Tuse/Tnew comparison
// ----------------------------------------------------------------------------
package hazard_stall_ctrl_pkg;

  localparam logic [1:0] TUSE_UNUSED      = 2'd3;
  localparam logic [4:0] REG_ZERO         = 5'd0;
  localparam int         MULT_CYCLES_DEF  = 5;
  localparam int         DIV_CYCLES_DEF   = 10;
  localparam int         CNT_W_DEF        = 4;

  // A downstream stage that may still be producing a register value.
  typedef struct packed {
    logic [4:0] wa;
    logic [1:0] tnew;
  } producer_t;

  // True when a consumer reading src at tuse must wait for producer p.
  // $0 is hard-wired and an unused operand (tuse = 3) can never be late,
  // because tnew never exceeds 3.
  function automatic logic hazard_hit(input logic [4:0] src,
                                      input logic [1:0] tuse,
                                      input producer_t  p);
    logic hit;
    hit = 1'b0;
    if (src == REG_ZERO) begin
      hit = 1'b0;
    end else if (tuse == TUSE_UNUSED) begin
      hit = 1'b0;
    end else if ((src == p.wa) && (tuse < p.tnew)) begin
      hit = 1'b1;
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_seq.sv
// ----------------------------------------------------------------------------
// md_busy_seq
// Busy sequencer for the multi-cycle mult/div unit. A start loads the
// operation latency; the counter then runs down to zero, one per cycle.
//   clk, reset   : clock, synchronous active-high reset
//   start_i      : E stage holds a mult/div this cycle
//   is_div_i     : qualifies start_i, 1 = div/divu
//   md_busy_o    : unit busy (count non-zero)
//   md_count_o   : remaining busy cycles
// ----------------------------------------------------------------------------
module md_busy_seq
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             is_div_i,
  output logic             md_busy_o,
  output logic [CNT_W-1:0] md_count_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LOAD_MUL = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_DIV = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: a start only loads when idle; a start while busy is ignored
  // and the run-down continues.
  always_comb begin
    count_d = count_q;
    if (start_i && (count_q == CNT_ZERO)) begin
      count_d = is_div_i ? LOAD_DIV : LOAD_MUL;
    end else if (count_q != CNT_ZERO) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= CNT_ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign md_count_o = count_q;
  assign md_busy_o  = (count_q != CNT_ZERO);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl
// Stall controller for the 5-stage MIPS core. Each cycle decides whether
// PC and F/D hold and whether D/E is flushed into a bubble, from Tuse/Tnew
// data hazards plus the mult/div busy state.
//   clk, reset           : clock, synchronous active-high reset
//   d_rs_* / d_rt_*      : D-stage source indices and Tuse (3 = unused)
//   d_is_md              : D-stage instruction uses the mult/div unit
//   e_wa/e_tnew, m_wa/m_tnew : E/M producers (wa 0 = none)
//   e_md_start/e_md_is_div   : mult/div launch in E
//   pc_en, fd_en, de_clr : pipeline register controls (same cycle)
//   md_busy, md_count    : mult/div sequencer state
//   stall_cnt            : stalled cycles since reset, wraps at 2^32
// ----------------------------------------------------------------------------
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       d_rs_addr,
  input  logic [4:0]       d_rt_addr,
  input  logic [1:0]       d_rs_tuse,
  input  logic [1:0]       d_rt_tuse,
  input  logic             d_is_md,
  input  logic [4:0]       e_wa,
  input  logic [1:0]       e_tnew,
  input  logic [4:0]       m_wa,
  input  logic [1:0]       m_tnew,
  input  logic             e_md_start,
  input  logic             e_md_is_div,
  output logic             pc_en,
  output logic             fd_en,
  output logic             de_clr,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_count,
  output logic [31:0]      stall_cnt
);

  producer_t   e_prod_s;
  producer_t   m_prod_s;
  logic        rs_haz_s;
  logic        rt_haz_s;
  logic        md_haz_s;
  logic        stall_s;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  assign e_prod_s = '{wa: e_wa, tnew: e_tnew};
  assign m_prod_s = '{wa: m_wa, tnew: m_tnew};

  md_busy_seq #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_seq (
    .clk        (clk),
    .reset      (reset),
    .start_i    (e_md_start),
    .is_div_i   (e_md_is_div),
    .md_busy_o  (md_busy),
    .md_count_o (md_count)
  );

  // Hazard detection against both in-flight producers.
  always_comb begin
    rs_haz_s = hazard_hit(d_rs_addr, d_rs_tuse, e_prod_s) |
               hazard_hit(d_rs_addr, d_rs_tuse, m_prod_s);
    rt_haz_s = hazard_hit(d_rt_addr, d_rt_tuse, e_prod_s) |
               hazard_hit(d_rt_addr, d_rt_tuse, m_prod_s);
    // The start cycle counts as busy so the next md op cannot slip in
    // before the counter has loaded.
    md_haz_s = d_is_md & (e_md_start | md_busy);
    stall_s  = rs_haz_s | rt_haz_s | md_haz_s;
  end

  // Pipeline controls. Reset forces every register to move: the PC register
  // lets its enable win over reset, so pc_en must be high for reset to land.
  always_comb begin
    if (reset) begin
      pc_en  = 1'b1;
      fd_en  = 1'b1;
      de_clr = 1'b1;
    end else begin
      pc_en  = ~stall_s;
      fd_en  = ~stall_s;
      de_clr = stall_s;
    end
  end

  // Next stall count; 32-bit add wraps naturally.
  always_comb begin
    if (stall_s) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_rs_addr, d_rt_addr, e_wa, m_wa;
  logic [1:0]  d_rs_tuse, d_rt_tuse, e_tnew, m_tnew;
  logic        d_is_md, e_md_start, e_md_is_div;
  logic        pc_en, fd_en, de_clr, md_busy;
  logic [3:0]  md_count;
  logic [31:0] stall_cnt;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_cnt = 32'd0;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk(clk), .reset(reset),
    .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
    .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .d_is_md(d_is_md),
    .e_wa(e_wa), .e_tnew(e_tnew), .m_wa(m_wa), .m_tnew(m_tnew),
    .e_md_start(e_md_start), .e_md_is_div(e_md_is_div),
    .pc_en(pc_en), .fd_en(fd_en), .de_clr(de_clr),
    .md_busy(md_busy), .md_count(md_count), .stall_cnt(stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    d_rs_addr = 5'd0; d_rt_addr = 5'd0;
    d_rs_tuse = 2'd3; d_rt_tuse = 2'd3;
    d_is_md = 1'b0;
    e_wa = 5'd0; e_tnew = 2'd0; m_wa = 5'd0; m_tnew = 2'd0;
    e_md_start = 1'b0; e_md_is_div = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    // hazard present while reset is held: controls must still be 1/1/1
    e_wa = 5'd8; e_tnew = 2'd2; d_rs_addr = 5'd8; d_rs_tuse = 2'd0;
    #1;
    checks++;
    if ({pc_en, fd_en, de_clr} !== 3'b111) begin
      failures++; $display("FAIL reset_ctrl got=%b want=111", {pc_en, fd_en, de_clr});
    end
    tick();
    tick();
    checks++;
    if (md_count !== 4'd0 || md_busy !== 1'b0) begin
      failures++; $display("FAIL reset_md got cnt=%0d busy=%b want 0/0", md_count, md_busy);
    end
    checks++;
    if (stall_cnt !== 32'd0) begin
      failures++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt);
    end
    set_idle();
    reset = 1'b0;
    exp_cnt = 32'd0;
    #1;
  endtask

  task automatic test_load_use();
    e_wa = 5'd8; e_tnew = 2'd2; d_rs_addr = 5'd8; d_rs_tuse = 2'd1;
    #1;
    checks++;
    if ({pc_en, fd_en, de_clr} !== 3'b001) begin
      failures++; $display("FAIL load_use_ctrl got=%b want=001", {pc_en, fd_en, de_clr});
    end
    exp_cnt = exp_cnt + 32'd1;
    tick();
    checks++;
    if (stall_cnt !== exp_cnt) begin
      failures++; $display("FAIL load_use_cnt got=%0d want=%0d", stall_cnt, exp_cnt);
    end
    // producer advanced to M with tnew 1: tuse 1 is not < 1
    e_wa = 5'd0; m_wa = 5'd8; m_tnew = 2'd1;
    #1;
    checks++;
    if ({pc_en, fd_en, de_clr} !== 3'b110) begin
      failures++; $display("FAIL load_use_resolved got=%b want=110", {pc_en, fd_en, de_clr});
    end
    // rt hazard against M stage
    set_idle();
    d_rt_addr = 5'd9; d_rt_tuse = 2'd0; m_wa = 5'd9; m_tnew = 2'd2;
    #1;
    checks++;
    if ({pc_en, fd_en, de_clr} !== 3'b001) begin
      failures++; $display("FAIL rt_m_hazard got=%b want=001", {pc_en, fd_en, de_clr});
    end
    exp_cnt = exp_cnt + 32'd1;
    tick();
    checks++;
    if (stall_cnt !== exp_cnt) begin
      failures++; $display("FAIL rt_m_cnt got=%0d want=%0d", stall_cnt, exp_cnt);
    end
    set_idle();
    #1;
  endtask

  task automatic test_exemptions();
    // $0 never stalls
    d_rs_addr = 5'd0; e_wa = 5'd0; e_tnew = 2'd2; d_rs_tuse = 2'd0;
    #1;
    checks++;
    if (pc_en !== 1'b1 || de_clr !== 1'b0) begin
      failures++; $display("FAIL zero_reg got pc_en=%b de_clr=%b want 1/0", pc_en, de_clr);
    end
    // unused rt
    set_idle();
    d_rt_addr = 5'd5; e_wa = 5'd5; e_tnew = 2'd2; d_rt_tuse = 2'd3;
    #1;
    checks++;
    if (pc_en !== 1'b1 || de_clr !== 1'b0) begin
      failures++; $display("FAIL unused_rt got pc_en=%b de_clr=%b want 1/0", pc_en, de_clr);
    end
    // tuse == tnew: forwarding covers it
    set_idle();
    d_rs_addr = 5'd7; d_rs_tuse = 2'd2; e_wa = 5'd7; e_tnew = 2'd2;
    #1;
    checks++;
    if (pc_en !== 1'b1 || de_clr !== 1'b0) begin
      failures++; $display("FAIL tuse_eq_tnew got pc_en=%b de_clr=%b want 1/0", pc_en, de_clr);
    end
    tick();
    checks++;
    if (stall_cnt !== exp_cnt) begin
      failures++; $display("FAIL exempt_cnt got=%0d want=%0d", stall_cnt, exp_cnt);
    end
    set_idle();
    #1;
  endtask

  task automatic test_div();
    logic [31:0] base;
    base = exp_cnt;
    e_md_start = 1'b1; e_md_is_div = 1'b1; d_is_md = 1'b1;
    #1;
    checks++;
    if ({pc_en, fd_en, de_clr} !== 3'b001) begin
      failures++; $display("FAIL div_start_stall got=%b want=001", {pc_en, fd_en, de_clr});
    end
    exp_cnt = exp_cnt + 32'd1;
    tick();
    e_md_start = 1'b0; e_md_is_div = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      #1;
      checks++;
      if (md_count !== 4'(11 - k)) begin
        failures++; $display("FAIL div_count t+%0d got=%0d want=%0d", k, md_count, 11 - k);
      end
      checks++;
      if (de_clr !== (k <= 10) || pc_en !== (k > 10)) begin
        failures++; $display("FAIL div_stall t+%0d got pc_en=%b de_clr=%b want %b/%b",
                             k, pc_en, de_clr, (k > 10), (k <= 10));
      end
      if (k <= 10) exp_cnt = exp_cnt + 32'd1;
      tick();
    end
    checks++;
    if (stall_cnt !== base + 32'd11) begin
      failures++; $display("FAIL div_stall_cnt got=%0d want=%0d", stall_cnt, base + 32'd11);
    end
    set_idle();
    #1;
  endtask

  task automatic test_mult_unrelated();
    e_md_start = 1'b1; e_md_is_div = 1'b0; d_is_md = 1'b0;
    #1;
    checks++;
    if (pc_en !== 1'b1 || de_clr !== 1'b0) begin
      failures++; $display("FAIL mult_start got pc_en=%b de_clr=%b want 1/0", pc_en, de_clr);
    end
    tick();
    e_md_start = 1'b0;
    #1;
    checks++;
    if (md_count !== 4'd5) begin
      failures++; $display("FAIL mult_load got=%0d want=5", md_count);
    end
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if (md_busy !== (k <= 5) || pc_en !== 1'b1) begin
        failures++; $display("FAIL mult_busy t+%0d got busy=%b pc_en=%b want %b/1",
                             k, md_busy, pc_en, (k <= 5));
      end
      tick();
    end
    checks++;
    if (stall_cnt !== exp_cnt) begin
      failures++; $display("FAIL mult_cnt got=%0d want=%0d", stall_cnt, exp_cnt);
    end
    set_idle();
    #1;
  endtask

  task automatic test_reset_mid_div();
    e_md_start = 1'b1; e_md_is_div = 1'b1;
    tick();
    e_md_start = 1'b0; e_md_is_div = 1'b0;
    tick(); tick(); tick(); tick();
    #1;
    checks++;
    if (md_count !== 4'd6) begin
      failures++; $display("FAIL mid_div_count got=%0d want=6", md_count);
    end
    d_is_md = 1'b1;
    #1;
    checks++;
    if ({pc_en, fd_en, de_clr} !== 3'b001) begin
      failures++; $display("FAIL mid_div_stall got=%b want=001", {pc_en, fd_en, de_clr});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({pc_en, fd_en, de_clr} !== 3'b111) begin
      failures++; $display("FAIL mid_div_reset_ctrl got=%b want=111", {pc_en, fd_en, de_clr});
    end
    tick();
    reset = 1'b0;
    exp_cnt = 32'd0;
    #1;
    checks++;
    if (md_count !== 4'd0 || md_busy !== 1'b0 || stall_cnt !== 32'd0) begin
      failures++; $display("FAIL mid_div_after got cnt=%0d busy=%b stall_cnt=%0d want 0/0/0",
                           md_count, md_busy, stall_cnt);
    end
    checks++;
    if ({pc_en, fd_en, de_clr} !== 3'b110) begin
      failures++; $display("FAIL mid_div_after_ctrl got=%b want=110", {pc_en, fd_en, de_clr});
    end
    set_idle();
    #1;
  endtask

  task automatic test_wrap();
    dut.stall_cnt_q = 32'hFFFF_FFFF;
    e_wa = 5'd3; e_tnew = 2'd3; d_rs_addr = 5'd3; d_rs_tuse = 2'd2;
    tick();
    checks++;
    if (stall_cnt !== 32'd0) begin
      failures++; $display("FAIL wrap got=%h want=00000000", stall_cnt);
    end
    set_idle();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_exemptions();
    test_div();
    test_mult_unrelated();
    test_reset_mid_div();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
